// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port indices and default RAM geometry.
package mem_arb_pkg;

  localparam int AW_DEFAULT = 9;
  localparam int DW_DEFAULT = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/memory_arbiter_rr_arb2.sv
// Two-input combinational grant logic.
// A lone request always wins. On a tie the port that was not granted last
// wins (round robin). With MEM_ARB_FIXED_PRIO_EN defined, port 0 always wins
// ties and last_gnt is ignored, so port 1 can starve.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

  // One-hot grant from the request pair and the previous winner.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        gnt = 2'b01;
`else
        gnt = (last_gnt == PORT1) ? 2'b01 : 2'b10;
`endif
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter/sequencer in front of a synchronous RAM with a one-cycle
// registered read. Each access walks IDLE -> ACCESS -> RESP -> IDLE, one cycle
// per state. Grant pulses during ACCESS, the RAM strobe is high only during
// ACCESS, read data is captured at the end of RESP, and done pulses in the
// following IDLE cycle (where a new grant decision is already taken).
// Handshake: a requester holds pX_req (with we/addr/wdata) until it sees
// pX_gnt; the command is latched on the IDLE edge that issues the grant, so
// later changes to we/addr/wdata are ignored. pX_done marks completion.
// Optional feature: MEM_ARB_FIXED_PRIO_EN (fixed port-0 priority on ties).
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output state_t        state
);

  state_t     state_next;
  logic [1:0] req_vec;
  logic [1:0] gnt_vec;
  logic       last_gnt;
  logic       cur_port;
  logic       cur_we;
  logic       take;
  logic       sel;

  assign req_vec = {p1_req, p0_req};
  assign take    = (state == IDLE) && (|req_vec);
  assign sel     = gnt_vec[1];

  rr_arb2 u_arb (
    .req      (req_vec),
    .last_gnt (last_gnt),
    .gnt      (gnt_vec)
  );

  // State register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and state-decoded outputs (grant, strobes, busy).
  always_comb begin
    state_next = state;
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (|req_vec) state_next = ACCESS;
      end
      ACCESS: begin
        p0_gnt     = (cur_port == PORT0);
        p1_gnt     = (cur_port == PORT1);
        mem_read   = ~cur_we;
        mem_write  = cur_we;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the winning command; the RAM address/data hold until the next grant.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cur_port  <= PORT0;
      cur_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_gnt  <= PORT1;
    end else if (take) begin
      cur_port  <= sel;
      cur_we    <= sel ? p1_we    : p0_we;
      mem_addr  <= sel ? p1_addr  : p0_addr;
      mem_wdata <= sel ? p1_wdata : p0_wdata;
      last_gnt  <= sel;
    end
  end

  // Capture read data at the end of RESP and pulse done for one cycle.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      if (state == RESP) begin
        if (cur_port == PORT0) begin
          p0_done <= 1'b1;
          if (!cur_we) p0_rdata <= mem_rdata;
        end else begin
          p1_done <= 1'b1;
          if (!cur_we) p1_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: RAM model, reset checks, clear mid-access,
// tie arbitration passes, a vector table and a short random run.
module tb_memory_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          clear;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_done, p1_gnt, p1_done;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;
  state_t        state;

  // Clock.
  always #5 clk = ~clk;

  memory_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .clear(clear),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .state(state)
  );

  // RAM model: registered read, junk on the output when no read was issued.
  logic [DW-1:0] ram [0:511];
  logic [DW-1:0] ram_q;
  logic          ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= '0;
      ram[9'h1FF] <= 32'h12345678;
      ram[9'h020] <= 32'h0BADF00D;
      ram_q <= '0;
    end else begin
      if (mem_write) ram[mem_addr] <= mem_wdata;
      ram_q <= mem_read ? ram[mem_addr] : (32'hDEAD0BAD ^ {23'd0, mem_addr});
    end
  end
  assign mem_rdata = ram_q;

  // Counters and comparison helper.
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state.
  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  logic [DW-1:0] m_rdata [2];
  logic [DW-1:0] seen_rdata [2];
  logic [DW-1:0] shadow [0:511];

  // Monitor: protocol checks and scoreboard pops, sampled on the falling edge.
  logic [1:0]    gnt_d1, gnt_d2;
  logic          prev_strobe;
  logic [AW-1:0] prev_addr;
  logic          mon_en = 1'b0;
  logic [DW-1:0] e;
  always @(negedge clk) begin
    if (clear || !mon_en) begin
      gnt_d1 = '0;
      gnt_d2 = '0;
      prev_strobe = 1'b0;
    end else begin
      if (mem_read || mem_write) check("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (p0_gnt || p1_gnt) check("single_gnt", 32'(p0_gnt & p1_gnt), 32'd0);
      if (prev_strobe) begin
        check("strobe_one_cycle", 32'(mem_read | mem_write), 32'd0);
        check("addr_stable", 32'(mem_addr), 32'(prev_addr));
      end
      if (gnt_d2[0] || p0_done) check("p0_gnt_to_done", 32'(p0_done), 32'(gnt_d2[0]));
      if (gnt_d2[1] || p1_done) check("p1_gnt_to_done", 32'(p1_done), 32'(gnt_d2[1]));
      if (p0_done) begin
        if (exp0_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL p0_unexpected_done: got done=1 expected no done at %0t", $time);
        end else begin
          e = exp0_q.pop_front();
          check("p0_rdata", p0_rdata, e);
          seen_rdata[0] = e;
          check("p1_rdata_hold", p1_rdata, seen_rdata[1]);
        end
      end
      if (p1_done) begin
        if (exp1_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL p1_unexpected_done: got done=1 expected no done at %0t", $time);
        end else begin
          e = exp1_q.pop_front();
          check("p1_rdata", p1_rdata, e);
          seen_rdata[1] = e;
          check("p0_rdata_hold", p0_rdata, seen_rdata[0]);
        end
      end
      gnt_d2 = gnt_d1;
      gnt_d1 = {p1_gnt, p0_gnt};
      prev_strobe = mem_read | mem_write;
      prev_addr = mem_addr;
    end
  end

  // Driver: one access on one port, issued at a falling edge while idle.
  task automatic do_access(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    int waited;
    if (port) begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    else      begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(port ? p1_gnt : p0_gnt) && waited < 10);
    check("gnt_latency", 32'(waited), 32'd1);
    // Drop the request and disturb the command to show it is no longer sampled.
    if (port) begin p1_req = 1'b0; p1_we = ~we; p1_addr = ~addr; p1_wdata = ~wdata; end
    else      begin p0_req = 1'b0; p0_we = ~we; p0_addr = ~addr; p0_wdata = ~wdata; end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Push the expected rdata (reads: supplied value; writes: unchanged) and drive.
  task automatic issue(input logic port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] rexp);
    logic [DW-1:0] x;
    x = we ? m_rdata[port] : rexp;
    m_rdata[port] = x;
    if (port) exp1_q.push_back(x);
    else      exp0_q.push_back(x);
    if (we) shadow[addr] = wdata;
    do_access(port, we, addr, wdata);
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;
  vec_t tbl [12];

  function automatic logic exp_tie_port(input int k);
`ifdef MEM_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return k[0];
`endif
  endfunction

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Main sequence.
  initial begin
    int k, cyc, last;
    logic gp, any_done, rport, rwe;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdat;

    clear = 1'b1; ram_init = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    for (int i = 0; i < 512; i++) shadow[i] = '0;
    shadow[9'h1FF] = 32'h12345678;
    shadow[9'h020] = 32'h0BADF00D;
    m_rdata[0] = '0; m_rdata[1] = '0;
    seen_rdata[0] = '0; seen_rdata[1] = '0;
    repeat (3) @(negedge clk);
    ram_init = 1'b0;

    // Reset state.
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    check("rst_p0_done", 32'(p0_done), 32'd0);
    check("rst_p1_done", 32'(p1_done), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_p1_rdata", p1_rdata, 32'd0);
    clear = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    check("idle_no_req_busy", 32'(busy), 32'd0);

    // Clear in the middle of a port 0 write.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h0A5; p0_wdata = 32'h11111111;
    @(negedge clk);
    check("clr_gnt", 32'(p0_gnt), 32'd1);
    check("clr_access_write", 32'(mem_write), 32'd1);
    check("clr_access_state", 32'(state), 32'(ACCESS));
    p0_req = 1'b0; clear = 1'b1;
    @(negedge clk);
    check("clr_state", 32'(state), 32'(IDLE));
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_mem_write", 32'(mem_write), 32'd0);
    check("clr_mem_read", 32'(mem_read), 32'd0);
    check("clr_done", 32'(p0_done), 32'd0);
    clear = 1'b0;
    any_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_done = any_done | p0_done | p1_done;
    end
    check("clr_no_done_after", 32'(any_done), 32'd0);
    check("clr_no_write", ram[9'h0A5], 32'd0);

    // Both ports hold their requests for four passes.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h020; p0_wdata = '0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h1FF; p1_wdata = '0;
    k = 0; cyc = 0; last = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (p0_gnt || p1_gnt) begin
        gp = p1_gnt;
        check("tie_order", 32'(gp), 32'(exp_tie_port(k)));
        m_rdata[gp] = gp ? shadow[9'h1FF] : shadow[9'h020];
        if (gp) exp1_q.push_back(m_rdata[1]);
        else    exp0_q.push_back(m_rdata[0]);
        if (k > 0) check("tie_spacing", 32'(cyc - last), 32'd3);
        else       check("tie_first_latency", 32'(cyc), 32'd1);
        last = cyc;
        k++;
      end
    end
    check("tie_passes", 32'(k), 32'd4);
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (3) @(negedge clk);

    // Vector table, applied back to back.
    tbl[0]  = '{1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'h12345678};
    tbl[3]  = '{1'b1, 1'b1, 9'h000, 32'hCAFEF00D, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 9'h000, 32'h0,        32'hCAFEF00D};
    tbl[5]  = '{1'b1, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};
    tbl[6]  = '{1'b0, 1'b1, 9'h1FF, 32'hA5A5A5A5, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'hA5A5A5A5};
    tbl[8]  = '{1'b0, 1'b0, 9'h020, 32'h0,        32'h0BADF00D};
    tbl[9]  = '{1'b1, 1'b1, 9'h100, 32'h00000001, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 9'h100, 32'h0,        32'h00000001};
    tbl[11] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'hA5A5A5A5};
    for (int i = 0; i < 12; i++)
      issue(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);

    // Random accesses near both ends of the address range.
    repeat (16) begin
      rport = 1'($urandom_range(0, 1));
      rwe   = 1'($urandom_range(0, 1));
      raddr = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(504, 511));
      rdat  = $urandom;
      issue(rport, rwe, raddr, rdat, shadow[raddr]);
    end

    repeat (2) @(negedge clk);
    check("sb_drain_p0", 32'(exp0_q.size()), 32'd0);
    check("sb_drain_p1", 32'(exp1_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
